// File: rtl/usb_tx_encoder_if.sv
// Byte-level handshake and status between the packet builder and the USB transmit encoder.
interface usb_tx_encoder_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_start, tx_data, tx_last, tx_valid,
    input  tx_ready, tx_busy, tx_done, tx_error
  );

  modport slave (
    input  tx_start, tx_data, tx_last, tx_valid,
    output tx_ready, tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC, LSB-first serialization, bit stuffing,
// NRZI line coding and EOP, fed one byte at a time through a holding register.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  usb_tx_encoder_if.slave  bus,
  output logic             d_plus,
  output logic             d_minus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       ones;
  logic             eop_cnt;
  logic             lvl;
  logic             cur_last;
  logic             hold_full;
  logic [7:0]       hold;
  logic             hold_last;
  logic [6:0]       pend;

  logic start, bit_end, in_ser, shift, byte_end, xfer, load, pkt_end;
  logic active_nxt, hold_full_nxt, nbit, nlvl;

  // Line pair for a differential level: 1 is J, 0 is K.
  function automatic logic [1:0] line_of(input logic lv);
    return {lv, ~lv};
  endfunction

  assign start         = (state == S_IDLE) && bus.tx_start;
  assign bit_end       = (state != S_IDLE) && (bit_cnt == CNT_MAX);
  assign in_ser        = (state == S_SYNC) || (state == S_DATA);
  assign shift         = bit_end && in_ser && (ones != 3'd6) && (bit_idx != 3'd7);
  assign byte_end      = bit_end && in_ser && (ones != 3'd6) && (bit_idx == 3'd7);
  assign xfer          = byte_end && hold_full && !((state == S_DATA) && cur_last);
  assign load          = bus.tx_valid && bus.tx_ready;
  assign pkt_end       = (state == S_EOP_J) && bit_end;
  // A byte boundary without a transfer always heads for EOP (last byte or underrun).
  assign active_nxt    = start || (in_ser && !(byte_end && !xfer));
  assign hold_full_nxt = load || (hold_full && !xfer && !pkt_end);
  assign nbit          = (bit_idx == 3'd7) ? hold[0] : pend[0];
  assign nlvl          = nbit ? lvl : ~lvl;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= S_IDLE;
      bit_cnt            <= '0;
      bit_idx            <= '0;
      ones               <= '0;
      eop_cnt            <= 1'b0;
      lvl                <= 1'b1;
      cur_last           <= 1'b0;
      hold_full          <= 1'b0;
      bus.tx_ready       <= 1'b0;
      bus.tx_busy        <= 1'b0;
      bus.tx_done        <= 1'b0;
      bus.tx_error       <= 1'b0;
      {d_plus, d_minus}  <= line_of(1'b1);
    end else begin
      bus.tx_done  <= 1'b0;
      bus.tx_error <= 1'b0;
      hold_full    <= hold_full_nxt;
      bus.tx_ready <= active_nxt && !hold_full_nxt;
      if (state != S_IDLE) bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.tx_start) begin
            // First SYNC bit is a 0, so the line toggles J->K on the start edge.
            state             <= S_SYNC;
            bit_cnt           <= '0;
            bit_idx           <= '0;
            ones              <= '0;
            cur_last          <= 1'b0;
            lvl               <= 1'b0;
            {d_plus, d_minus} <= line_of(1'b0);
            bus.tx_busy       <= 1'b1;
          end
        end
        S_SYNC, S_DATA: begin
          if (bit_end) begin
            if (ones == 3'd6) begin
              lvl               <= ~lvl;
              {d_plus, d_minus} <= line_of(~lvl);
              ones              <= '0;
            end else if ((bit_idx != 3'd7) || xfer) begin
              lvl               <= nlvl;
              {d_plus, d_minus} <= line_of(nlvl);
              ones              <= nbit ? ones + 3'd1 : 3'd0;
              bit_idx           <= bit_idx + 3'd1;
              if (xfer) begin
                state    <= S_DATA;
                cur_last <= hold_last;
              end
            end else begin
              state             <= S_EOP_SE0;
              eop_cnt           <= 1'b0;
              {d_plus, d_minus} <= 2'b00;
              bus.tx_error      <= !((state == S_DATA) && cur_last);
            end
          end
        end
        S_EOP_SE0: begin
          if (bit_end) begin
            if (eop_cnt) begin
              state             <= S_EOP_J;
              {d_plus, d_minus} <= line_of(1'b1);
            end else begin
              eop_cnt <= 1'b1;
            end
          end
        end
        S_EOP_J: begin
          if (bit_end) begin
            state       <= S_IDLE;
            lvl         <= 1'b1;
            bus.tx_busy <= 1'b0;
            bus.tx_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // pend holds the not-yet-sent bits of the current byte; bit 0 is the next one out.
  always_ff @(posedge clk) begin
    if (load) begin
      hold      <= bus.tx_data;
      hold_last <= bus.tx_last;
    end
    if (start)      pend <= 7'b100_0000;
    else if (xfer)  pend <= hold[7:1];
    else if (shift) pend <= {1'b0, pend[6:1]};
  end

endmodule
